// File: rtl/alu.sv
// Registered integer ALU: combinational result from op/in1/in2, captured into out when enable=1.
// Define ALU_DIV_EN to build the combinational divider; otherwise the DIV opcode returns 0.
module alu #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [0:3]           op,
  input  logic [0:WORD_SIZE-1] in1,
  input  logic [0:WORD_SIZE-1] in2,
  input  logic                 enable,
  output logic [0:WORD_SIZE-1] out
);

  localparam logic [0:3] ALU_ADD   = 4'h0;
  localparam logic [0:3] ALU_SUB   = 4'h1;
  localparam logic [0:3] ALU_MUL   = 4'h2;
  localparam logic [0:3] ALU_DIV   = 4'h3;
  localparam logic [0:3] ALU_AND   = 4'h4;
  localparam logic [0:3] ALU_OR    = 4'h5;
  localparam logic [0:3] ALU_XOR   = 4'h6;
  localparam logic [0:3] ALU_SLT   = 4'h7;
  localparam logic [0:3] ALU_SHIFT = 4'h8;
  localparam logic [0:3] ALU_SHR   = 4'h9;
  localparam logic [0:3] ALU_NOT   = 4'hA;

  localparam logic [0:WORD_SIZE-1] ALL_ONES = {WORD_SIZE{1'b1}};
  localparam logic [0:WORD_SIZE-1] ZERO     = {WORD_SIZE{1'b0}};
  localparam logic [0:WORD_SIZE-1] WIDTH_W  = WORD_SIZE[WORD_SIZE-1:0];

  logic [0:WORD_SIZE-1] result;
  logic [0:WORD_SIZE-1] out_d;
  logic [0:WORD_SIZE-1] out_q;
  logic                 shift_overflow;
  logic                 signed_lt;

  // Vectors are MSB-first ([0:N-1]) but arithmetic treats them as ordinary unsigned numbers.
  always_comb begin
    shift_overflow = (in2 >= WIDTH_W);
    signed_lt      = ($signed(in1) < $signed(in2));
    result         = ZERO;
    case (op)
      ALU_ADD:   result = in1 + in2;
      ALU_SUB:   result = in1 - in2;
      ALU_MUL:   result = in1 * in2;
`ifdef ALU_DIV_EN
      ALU_DIV:   result = (in2 == ZERO) ? ALL_ONES : (in1 / in2);
`else
      ALU_DIV:   result = ZERO;
`endif
      ALU_AND:   result = in1 & in2;
      ALU_OR:    result = in1 | in2;
      ALU_XOR:   result = in1 ^ in2;
      ALU_SLT:   result = {{(WORD_SIZE-1){1'b0}}, signed_lt};
      ALU_SHIFT: result = shift_overflow ? ZERO : (in1 << in2);
      ALU_SHR:   result = shift_overflow ? ZERO : (in1 >> in2);
      ALU_NOT:   result = ~in1;
      default:   result = ZERO;
    endcase
  end

  always_comb begin
    out_d = enable ? result : out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= ZERO;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results queue up as stimulus is driven
// and are popped and compared one edge later.
module tb_alu;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic [0:3]   op;
   logic [0:W-1] in1;
   logic [0:W-1] in2;
   logic         enable;
   logic [0:W-1] out;

   logic [0:W-1] expQueue[$];
   int           checkCount;
   int           passCount;

   alu #(.WORD_SIZE(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .op     (op),
      .in1    (in1),
      .in2    (in2),
      .enable (enable),
      .out    (out)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check is counted here
   task automatic checkOutput(input string tag, input logic [0:W-1] actual,
                              input logic [0:W-1] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: actual=0x%04h required=0x%04h", tag, actual, expected);
      else
         passCount++;
   endtask

   // Drive one op with enable=1, queue its expectation, then compare after the edge
   task automatic applyStimulus(input string tag, input logic [0:3] o,
                                input logic [0:W-1] a, input logic [0:W-1] b,
                                input logic [0:W-1] expected);
      logic [0:W-1] exp;
      @(negedge clk);
      op     = o;
      in1    = a;
      in2    = b;
      enable = 1'b1;
      expQueue.push_back(expected);
      @(posedge clk);
      #1;
      if (expQueue.size() == 0) begin
         checkOutput({tag, "_queue"}, 16'h0001, 16'h0000);
      end else begin
         exp = expQueue.pop_front();
         checkOutput(tag, out, exp);
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n  = 1'b0;
      enable = 1'b1;
      op     = 4'h0;
      in1    = 16'd5;
      in2    = 16'd7;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("add",   4'h0, 16'd5,  16'd7,  16'd12);
      applyStimulus("sub",   4'h1, 16'd15, 16'd4,  16'd11);
      applyStimulus("mul",   4'h2, 16'd4,  16'd9,  16'd36);
`ifdef ALU_DIV_EN
      applyStimulus("div",   4'h3, 16'd6,  16'd2,  16'd3);
      applyStimulus("div0",  4'h3, 16'd9,  16'd0,  16'hFFFF);
`else
      applyStimulus("div",   4'h3, 16'd6,  16'd2,  16'd0);
      applyStimulus("div0",  4'h3, 16'd9,  16'd0,  16'd0);
`endif
      applyStimulus("and",   4'h4, 16'd9,  16'd12, 16'd8);
      applyStimulus("or",    4'h5, 16'd9,  16'd12, 16'd13);
      applyStimulus("xor",   4'h6, 16'd9,  16'd12, 16'd5);
      applyStimulus("shl",   4'h8, 16'd5,  16'd1,  16'd10);
      applyStimulus("shr",   4'h9, 16'd10, 16'd1,  16'd5);
      applyStimulus("not",   4'hA, 16'd0,  16'd3,  16'hFFFF);
      applyStimulus("slt_a", 4'h7, 16'd6,  16'd7,  16'd1);
      applyStimulus("slt_b", 4'h7, 16'd7,  16'd6,  16'd0);
      applyStimulus("slt_c", 4'h7, 16'hFFFF, 16'd1, 16'd1);
      applyStimulus("slt_d", 4'h7, 16'd5,  16'd5,  16'd0);
      applyStimulus("slt_e", 4'h7, 16'd1,  16'h8000, 16'd0);
      applyStimulus("add_wrap", 4'h0, 16'hFFFF, 16'd1, 16'd0);
      applyStimulus("sub_wrap", 4'h1, 16'd3, 16'd4, 16'hFFFF);
      applyStimulus("mul_wrap", 4'h2, 16'h0100, 16'h0101, 16'h0100);
      applyStimulus("shl_16", 4'h8, 16'd1, 16'd16, 16'd0);
      applyStimulus("shl_15", 4'h8, 16'd1, 16'd15, 16'h8000);
      applyStimulus("shr_big", 4'h9, 16'h8000, 16'd200, 16'd0);
      applyStimulus("shr_15", 4'h9, 16'h8000, 16'd15, 16'd1);
      applyStimulus("rsvd_b", 4'hB, 16'd5, 16'd7, 16'd0);
      applyStimulus("rsvd_f", 4'hF, 16'd5, 16'd7, 16'd0);

      // Hold: out must keep 12 while enable is low and inputs change
      applyStimulus("add_hold", 4'h0, 16'd5, 16'd7, 16'd12);
      @(negedge clk);
      enable = 1'b0;
      op     = 4'h1;
      in1    = 16'd15;
      in2    = 16'd4;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("hold_%0d", i), out, 16'd12);
         in1 = in1 + 16'd1;
      end

      // Asynchronous reset between edges clears out without a clock edge
      applyStimulus("pre_reset", 4'h0, 16'd1, 16'd2, 16'd3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", out, 16'h0000);
      enable = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_over_enable", out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("post_reset", 4'h6, 16'hA5A5, 16'hFFFF, 16'h5A5A);

      if (expQueue.size() != 0)
         checkOutput("queue_empty", 16'(expQueue.size()), 16'h0000);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
